uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single UART transmitter between N_REQ byte sources (e.g. echo path, status reporter, debug port). It accepts one byte per grant over a valid/ready handshake and drives the transmitter's word and start strobe. It then waits for the transmitter's end-of-frame flag and enforces an inter-frame gap before the next grant. A watchdog aborts a grant if the transmitter never reports completion.

---
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources,
// with an inter-frame gap and a watchdog on the transmitter's end-of-frame flag.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               res,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_word,
    output logic               tx_start,
    input  logic               tx_done,
    output logic [2:0]         grant_id,
    output logic               busy,
    output logic               err_timeout
);

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [2:0]         r_grant;
    logic [2:0]         r_rr_ptr;
    logic [7:0]         r_word;
    logic [15:0]        r_cnt;
    logic               r_done_d;

    logic [2:0]         w_pick;
    logic [2:0]         w_ptr_nx;
    logic [7:0]         w_data;
    logic [N_REQ-1:0]   w_gnt_oh;
    logic               w_hit;
    logic               w_edge;
    logic               w_err;

    // First valid index at or after ptr, wrapping modulo N_REQ.
    function automatic logic [2:0] f_pick(input logic [N_REQ-1:0] v, input logic [2:0] ptr);
        logic [2:0] sel;
        sel = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (v[j] && (j == (int'(ptr) + i) % N_REQ)) begin
                    sel = 3'(j);
                end
            end
        end
        return sel;
    endfunction

    function automatic logic [2:0] f_next(input logic [2:0] g);
        return 3'((int'(g) + 1) % N_REQ);
    endfunction

    always_comb begin
        w_gnt_oh = '0;
        w_data   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == 3'(i)) begin
                w_gnt_oh[i] = 1'b1;
                w_data      = req_data[8*i +: 8];
            end
        end
    end

    assign w_pick   = f_pick(req_valid, r_rr_ptr);
    assign w_ptr_nx = f_next(r_grant);
    assign w_hit    = |(req_valid & w_gnt_oh);
    // A level-style flag left high from the previous frame must not count as done.
    assign w_edge   = tx_done & ~r_done_d;

    always_comb begin
        w_state_nx = r_state;
        w_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) w_state_nx = S_ACCEPT;
            end
            S_ACCEPT: begin
                w_state_nx = w_hit ? S_START : S_IDLE;
            end
            S_START: begin
                w_state_nx = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (w_edge) begin
                    w_state_nx = S_GAP;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nx = S_GAP;
                    w_err      = 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt >= GAP_LAST) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_word   <= '0;
            r_cnt    <= '0;
            r_done_d <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_done_d <= tx_done;
            case (r_state)
                S_IDLE: begin
                    if (|req_valid) r_grant <= w_pick;
                end
                S_ACCEPT: begin
                    if (w_hit) begin
                        r_word   <= w_data;
                        r_rr_ptr <= w_ptr_nx;
                    end
                end
                S_START: begin
                    r_cnt <= '0;
                end
                S_WAIT_DONE: begin
                    r_cnt <= (w_state_nx == S_GAP) ? 16'd0 : r_cnt + 16'd1;
                end
                S_GAP: begin
                    r_cnt <= r_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the registered state so reset forces them low.
    assign req_ready   = (r_state == S_ACCEPT) ? w_gnt_oh : '0;
    assign tx_start    = (r_state == S_START);
    assign tx_word     = r_word;
    assign grant_id    = r_grant;
    assign busy        = (r_state != S_IDLE);
    assign err_timeout = w_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed-sequence bench for uart_tx_arbiter with randomized bytes and frame
// lengths, predicted by a cycle-count model of grants, pointer and gap timing.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 6;
    localparam int TMO = 50;

    logic           clk = 1'b0;
    logic           res = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_word;
    logic           tx_start;
    logic           tx_done;
    logic [2:0]     grant_id;
    logic           busy;
    logic           err_timeout;

    int             checks = 0;
    int             errors = 0;
    int             m_ptr  = 0;
    logic [7:0]     bytes [N];
    logic [7:0]     last_word = 8'h00;

    uart_tx_arbiter #(
        .N_REQ(N),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .res(res),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_word(tx_word),
        .tx_start(tx_start),
        .tx_done(tx_done),
        .grant_id(grant_id),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_data();
        req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
    endtask

    task automatic rnd_bytes();
        for (int i = 0; i < N; i++) bytes[i] = 8'($urandom);
        set_data();
    endtask

    // Model: first valid requester counting upward from the pointer, modulo N.
    function automatic int pick(input logic [N-1:0] v);
        for (int off = 0; off < N; off++) begin
            if (v[(m_ptr + off) % N]) return (m_ptr + off) % N;
        end
        return -1;
    endfunction

    // Called inside an IDLE cycle before its closing edge; returns in the IDLE
    // cycle that follows the gap. hi: WAIT cycles with tx_done still high,
    // lo: WAIT cycles low, then the completion cycle (rise, or none if tmo).
    task automatic frame(input logic [N-1:0] v, input int hi, input int lo,
                         input bit tmo, input bit level);
        int         g;
        logic [7:0] b;
        req_valid = v;
        set_data();
        g = pick(v);
        b = bytes[g];
        #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_ready", 32'(req_ready), 0);
        nxt(); smp();
        chk("accept_ready", 32'(req_ready), 32'(1 << g));
        chk("accept_gid", 32'(grant_id), 32'(g));
        chk("accept_start", 32'(tx_start), 0);
        chk("accept_busy", 32'(busy), 1);
        nxt(); smp();
        chk("start_strobe", 32'(tx_start), 1);
        chk("start_word", 32'(tx_word), 32'(b));
        chk("start_ready", 32'(req_ready), 0);
        m_ptr     = (g + 1) % N;
        last_word = b;
        for (int k = 0; k < hi + lo; k++) begin
            nxt();
            tx_done = (k < hi);
            smp();
            chk("wait_start", 32'(tx_start), 0);
            chk("wait_err", 32'(err_timeout), 0);
            chk("wait_busy", 32'(busy), 1);
            chk("wait_word", 32'(tx_word), 32'(b));
        end
        nxt();
        tx_done = !tmo;
        smp();
        chk("end_err", 32'(err_timeout), 32'(tmo));
        chk("end_busy", 32'(busy), 1);
        for (int k = 0; k < GAP; k++) begin
            nxt();
            if (!level) tx_done = 1'b0;
            smp();
            chk("gap_busy", 32'(busy), 1);
            chk("gap_err", 32'(err_timeout), 0);
            chk("gap_ready", 32'(req_ready), 0);
        end
        nxt();
        if (!level) tx_done = 1'b0;
        smp();
        chk("post_gap_idle", 32'(busy), 0);
        chk("hold_word", 32'(tx_word), 32'(b));
        chk("hold_gid", 32'(grant_id), 32'(g));
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        tx_done   = 1'b0;
        for (int i = 0; i < N; i++) bytes[i] = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_word", 32'(tx_word), 0);
        chk("rst_start", 32'(tx_start), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_timeout), 0);
        smp();
        res = 1'b1;
        nxt(); smp();

        // Round robin with all four valid: 0,1,2,3,0
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        for (int f = 0; f < 5; f++) frame(4'b1111, 0, $urandom_range(1, 30), 0, 0);

        // Single requester served back-to-back
        rnd_bytes();
        bytes[0] = 8'hA5;
        frame(4'b0001, 0, 40, 0, 0);
        frame(4'b0001, 0, $urandom_range(1, 30), 0, 0);

        // Serve through requester 3, then only 1 and 2 pending
        rnd_bytes();
        for (int f = 0; f < 3; f++) frame(4'b1111, 0, $urandom_range(1, 20), 0, 0);
        frame(4'b0110, 0, $urandom_range(1, 20), 0, 0);
        frame(4'b0110, 0, $urandom_range(1, 20), 0, 0);

        // Valid dropped during ACCEPT: no start, pointer unchanged
        req_valid = 4'b1000;
        nxt();
        req_valid = 4'b0000;
        smp();
        chk("drop_ready", 32'(req_ready), 32'(4'b1000));
        chk("drop_gid", 32'(grant_id), 3);
        nxt(); smp();
        chk("drop_start", 32'(tx_start), 0);
        chk("drop_busy", 32'(busy), 0);
        chk("drop_word", 32'(tx_word), 32'(last_word));
        nxt(); smp();
        chk("drop_idle", 32'(busy), 0);
        rnd_bytes();
        frame(4'b1111, 0, $urandom_range(1, 20), 0, 0);

        // Level-style done held high across two frames
        rnd_bytes();
        frame(4'b1111, 0, $urandom_range(1, 20), 0, 1);
        frame(4'b1111, $urandom_range(2, 8), $urandom_range(1, 5), 0, 1);
        frame(4'b1111, 0, $urandom_range(1, 20), 0, 0);

        // Completion edge on the timeout cycle, then a real timeout, then normal
        rnd_bytes();
        frame(4'b1111, 0, TMO - 1, 0, 0);
        frame(4'b1111, 0, TMO - 1, 1, 0);
        frame(4'b1111, 0, $urandom_range(1, 20), 0, 0);

        // Reset asserted while waiting for completion
        rnd_bytes();
        req_valid = 4'b0010;
        nxt(); nxt(); nxt(); nxt();
        res = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_word", 32'(tx_word), 0);
        chk("mid_rst_gid", 32'(grant_id), 0);
        chk("mid_rst_start", 32'(tx_start), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        req_valid = 4'b0000;
        nxt(); smp();
        chk("in_rst_start", 32'(tx_start), 0);
        res   = 1'b1;
        m_ptr = 0;
        nxt(); smp();
        chk("rel_start", 32'(tx_start), 0);
        chk("rel_busy", 32'(busy), 0);
        rnd_bytes();
        frame(4'b0110, 0, $urandom_range(1, 20), 0, 0);
        frame(4'b0100, 0, $urandom_range(1, 20), 0, 0);
        req_valid = 4'b0000;
        nxt(); smp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
